// File: rtl/bp_update_ctrl_if.sv
// Fetch/EX/predictor-side bundle for bp_update_ctrl.
//   alloc_*    : fetch pushes a predicted branch (alloc_ready back-pressures)
//   res_*      : EX resolves the oldest in-flight branch
//   we_bp, update_res, write_pc, mispredict : registered predictor-table write
// master = fetch/EX side, slave = bp_update_ctrl.
interface bp_update_ctrl_if #(
  parameter int ADDR_WIDTH = 26
);
  logic                  alloc_valid;
  logic [ADDR_WIDTH-1:0] alloc_pc;
  logic                  alloc_pred;
  logic                  alloc_ready;
  logic                  res_valid;
  logic                  res_taken;
  logic                  we_bp;
  logic                  update_res;
  logic [ADDR_WIDTH-1:0] write_pc;
  logic                  mispredict;

  modport master (
    output alloc_valid, alloc_pc, alloc_pred, res_valid, res_taken,
    input  alloc_ready, we_bp, update_res, write_pc, mispredict
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_pred, res_valid, res_taken,
    output alloc_ready, we_bp, update_res, write_pc, mispredict
  );
endinterface

// File: rtl/bp_update_ctrl.sv
// bp_update_ctrl: in-order queue of in-flight predicted branches. When the
// oldest branch resolves, trains the 2-bit predictor through a single
// registered write port one cycle later and flags mispredictions.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   bus (slave)    : alloc/resolve handshake and predictor write port
//   flush          : discard all in-flight entries
//   count          : current occupancy
//   err_underflow  : sticky, resolve seen while empty
//   branch_cnt, mispred_cnt : saturating statistics (only with BP_STATS_EN)
// Optional feature macro: BP_STATS_EN
module bp_update_ctrl #(
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 26,
  parameter int CNT_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bp_update_ctrl_if.slave      bus,
  input  logic                 flush,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 err_underflow
`ifdef BP_STATS_EN
  ,
  output logic [31:0]          branch_cnt,
  output logic [31:0]          mispred_cnt
`endif
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pred;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic [PTR_W-1:0]      head, head_nxt, tail, tail_nxt;
  entry_t                mem [DEPTH];

  logic                  full, empty, alloc_ok, res_ok, mis_now;
  logic                  we_q, res_q, mis_q, uf_q;
  logic [ADDR_WIDTH-1:0] pc_q;

  assign full     = (state == FULL);
  assign empty    = (state == EMPTY);
  // Flush kills a same-cycle alloc but still lets a same-cycle resolve pop.
  assign alloc_ok = bus.alloc_valid & ~full & ~flush;
  assign res_ok   = bus.res_valid & ~empty;
  assign mis_now  = mem[head].pred != bus.res_taken;

  assign bus.alloc_ready = ~full;
  assign bus.we_bp       = we_q;
  assign bus.update_res  = res_q;
  assign bus.write_pc    = pc_q;
  assign bus.mispredict  = mis_q;
  assign count           = cnt;
  assign err_underflow   = uf_q;

  always_comb begin
    cnt_nxt  = cnt;
    head_nxt = head;
    tail_nxt = tail;
    if (flush) begin
      cnt_nxt  = '0;
      head_nxt = '0;
      tail_nxt = '0;
    end else begin
      head_nxt = head + PTR_W'(res_ok);
      tail_nxt = tail + PTR_W'(alloc_ok);
      if (alloc_ok && !res_ok) cnt_nxt = cnt + CNT_WIDTH'(1);
      if (res_ok && !alloc_ok) cnt_nxt = cnt - CNT_WIDTH'(1);
    end
    state_nxt = PARTIAL;
    if (cnt_nxt == '0)                   state_nxt = EMPTY;
    else if (cnt_nxt == CNT_WIDTH'(DEPTH)) state_nxt = FULL;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      cnt   <= '0;
      head  <= '0;
      tail  <= '0;
      we_q  <= 1'b0;
      mis_q <= 1'b0;
      res_q <= 1'b0;
      pc_q  <= '0;
      uf_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      head  <= head_nxt;
      tail  <= tail_nxt;
      we_q  <= res_ok;
      mis_q <= res_ok & mis_now;
      if (res_ok) begin
        res_q <= bus.res_taken;
        pc_q  <= mem[head].pc;
      end
      if (bus.res_valid && empty) uf_q <= 1'b1;
    end
  end

  // Entry payload needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (alloc_ok) mem[tail] <= '{pc: bus.alloc_pc, pred: bus.alloc_pred};
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (res_ok && branch_cnt != '1)             branch_cnt  <= branch_cnt + 32'd1;
      if (res_ok && mis_now && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: doc/bp_update_ctrl.md
Name: bp_update_ctrl

Overview:
- Tracks in-flight predicted branches between fetch and execute in a small in-order queue.
- When the oldest branch resolves, drives the single update write port of the two-bit branch predictor table (we_bp, update_res, write_pc) and flags mispredictions.
- Sits between the fetch-stage predictor lookup and the EX-stage branch resolution logic.
- Serialises all predictor training through one registered write per cycle.

Parameters:
- DEPTH, 4: number of in-flight branch entries. Power of two, ≥2.
- ADDR_WIDTH, 26: PC width; matches the predictor's write_pc.
- CNT_WIDTH, 3: occupancy width, equal to $clog2(DEPTH)+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- alloc_valid  in  1  fetch issues a predicted branch this cycle
- alloc_pc  in  ADDR_WIDTH  PC of the issued branch
- alloc_pred  in  1  direction predicted at fetch (1 = taken)
- alloc_ready  out  1  queue can accept an entry; combinational, equals !full
- res_valid  in  1  EX resolves the oldest in-flight branch
- res_taken  in  1  actual direction of the resolved branch
- flush  in  1  pipeline flush; discards all in-flight entries
- we_bp  out  1  predictor table write enable (registered)
- update_res  out  1  outcome to train with (registered)
- write_pc  out  ADDR_WIDTH  PC to train (registered)
- mispredict  out  1  registered pulse, same cycle as we_bp, set when prediction ≠ outcome
- count  out  CNT_WIDTH  current occupancy
- err_underflow  out  1  sticky; set on res_valid while queue is empty

Behaviour:
- Storage: circular buffer of DEPTH entries {pc, pred}. head/tail pointers are log2(DEPTH) bits and wrap naturally DEPTH-1 → 0.
- Occupancy FSM over count:
  - EMPTY (count = 0), PARTIAL (0 < count < DEPTH), FULL (count = DEPTH).
  - alloc only: count + 1.
  - res only: count − 1.
  - Both alloc and res: count unchanged.
  - full = (count == DEPTH); empty = (count == 0).
- Alloc:
  - Accepted when alloc_valid & alloc_ready & !flush.
  - Writes the entry at tail; tail advances.
  - alloc_valid while FULL is dropped, with no state change. Fetch must stall on !alloc_ready.
- Resolve:
  - Accepted when res_valid & !empty.
  - Reads the entry at head; head advances.
  - Next cycle: we_bp = 1, write_pc = head.pc, update_res = res_taken, mispredict = (head.pred != res_taken).
  - Latency from res_valid to we_bp is exactly 1 cycle. At most one update per cycle; there is no backpressure on the predictor side.
- Underflow: res_valid while EMPTY sets err_underflow, which stays set until reset. No pop, no we_bp, count stays 0.
- Simultaneous alloc + res while EMPTY: the alloc is accepted; the res is an underflow. There is no same-cycle bypass.
- Simultaneous alloc + res while FULL: alloc_ready is 0, so the alloc is dropped and the res pops. Next cycle count = DEPTH − 1.
- Flush:
  - A res_valid in the same cycle is processed first: the head update is still emitted next cycle.
  - Then all entries are discarded: head = tail = 0, count = 0.
  - An alloc in the flush cycle is dropped.
  - Flush never sets err_underflow except via the res rule above.
- Registered outputs:
  - we_bp and mispredict are high for exactly one cycle per resolve.
  - update_res and write_pc hold their last value when we_bp = 0.
- Reset (synchronous, including mid-operation):
  - head = tail = 0, count = 0.
  - we_bp = 0, mispredict = 0, update_res = 0, write_pc = 0, err_underflow = 0.
  - alloc_ready = 1 in the first cycle after reset.
  - Any pending update from the reset cycle is discarded.

Optional Feature:
- Macro BP_STATS_EN.
- When defined, adds two outputs:
  - branch_cnt, out, 32: increments on every accepted resolve.
  - mispred_cnt, out, 32: increments on every resolve with mispredict.
  - Both saturate at 32'hFFFF_FFFF, are cleared by reset, and are unaffected by flush.
- When undefined, neither the ports nor the counter logic exist. All other behaviour is identical.

Test Plan:
- Alloc {pc=0x40,pred=1}, then res_taken=0 → next cycle we_bp=1, write_pc=0x40, update_res=0, mispredict=1, count=0.
- Alloc 4 entries (DEPTH=4) → count=4, alloc_ready=0. A 5th alloc is dropped. Four resolves emit the PCs in order 1,2,3,4 on consecutive cycles.
- At count=4, assert alloc + res together → the head update is emitted, count=3, the alloc is not stored. Repeat with count=2 → count stays 2, the alloc is stored.
- Wrap-around: 10 alloc/res pairs with distinct PCs → write_pc sequence matches alloc order and err_underflow stays 0.
- Flush with count=3 and res_valid=1 in the same cycle → one update for the head entry, count=0, a later res_valid sets err_underflow=1 with no we_bp.
- Assert rst_n=0 with count=2 and a resolve pending → the next cycle shows we_bp=0, count=0, alloc_ready=1. With BP_STATS_EN, branch_cnt and mispred_cnt are 0.
